wb_arb: RTL and testbench

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb.sv | 199 +++++++++++++++++++
 tb/tb_wb_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb.sv
// ---------------------------------------------------------------------------
// wb_arb -- writeback arbiter with register-file write stage and a busy
// scoreboard.
//
// Four result sources (lsu, div, mul, alu) compete for the single
// register-file write port. At most one source is granted per cycle. The
// granted result is registered and drives rd_wr_en/rd_addr/rd_data one cycle
// later. Results addressed to x0 are accepted but never written.
//
// busy[n] marks registers with an outstanding write. A bit is set by an
// issue and cleared by the matching register-file write. If both happen in
// the same cycle, the set wins. flush clears every bit except one set by an
// issue in that same cycle.
//
// Configuration macro:
//   WB_RR_ARB_EN  defined   : round-robin arbitration in the order
//                             lsu, div, mul, alu.
//                 undefined : fixed priority lsu > div > mul > alu, with no
//                             pointer state.
//
// Ports:
//   clk, rst_n                   core clock, asynchronous active-low reset
//   <s>_wb_valid/rd_addr/rd_data result from source s (lsu, div, mul, alu)
//   <s>_wb_ready                 grant to source s, combinational
//   iss_valid, iss_rd_addr       issue of an instruction with a destination
//   flush                        clears the scoreboard
//   rd_wr_en, rd_addr, rd_data   register-file write port
//   busy                         per-register pending-write flags
// ---------------------------------------------------------------------------
package wb_arb_pkg;
  localparam int XLEN = 32;

  // Source index; it is also the bit position in the request/grant vectors.
  typedef enum logic [1:0] {
    SRC_LSU = 2'd0,
    SRC_DIV = 2'd1,
    SRC_MUL = 2'd2,
    SRC_ALU = 2'd3
  } src_e;
endpackage

module wb_arb
  import wb_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,

  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd_addr,
  input  logic [XLEN-1:0] lsu_wb_rd_data,
  output logic            lsu_wb_ready,

  input  logic            div_wb_valid,
  input  logic [4:0]      div_wb_rd_addr,
  input  logic [XLEN-1:0] div_wb_rd_data,
  output logic            div_wb_ready,

  input  logic            mul_wb_valid,
  input  logic [4:0]      mul_wb_rd_addr,
  input  logic [XLEN-1:0] mul_wb_rd_data,
  output logic            mul_wb_ready,

  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd_addr,
  input  logic [XLEN-1:0] alu_wb_rd_data,
  output logic            alu_wb_ready,

  input  logic            iss_valid,
  input  logic [4:0]      iss_rd_addr,
  input  logic            flush,

  output logic            rd_wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic [31:0]     busy
);

  logic [3:0]      w_req;
  logic            w_any;
  logic [1:0]      w_gnt_idx;
  logic [3:0]      w_gnt;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic            w_wr;

  assign w_req = {alu_wb_valid, mul_wb_valid, div_wb_valid, lsu_wb_valid};
  assign w_any = |w_req;

`ifdef WB_RR_ARB_EN
  // Points at the source with the highest priority in the current cycle.
  logic [1:0] r_ptr;

  // NOTE: every variable assigned in an always_comb gets a default on entry.
  // Otherwise a path that leaves the variable unassigned infers a latch.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_gnt_idx = SRC_LSU;
    found     = 1'b0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!found && w_req[idx]) begin
        found     = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // The pointer moves to the source after the granted one. With no output
  // back-pressure, any grant is also a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SRC_LSU;
    end else if (w_any) begin
      r_ptr <= w_gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    w_gnt_idx = SRC_LSU;
    if (lsu_wb_valid)      w_gnt_idx = SRC_LSU;
    else if (div_wb_valid) w_gnt_idx = SRC_DIV;
    else if (mul_wb_valid) w_gnt_idx = SRC_MUL;
    else if (alu_wb_valid) w_gnt_idx = SRC_ALU;
  end
`endif

  assign w_gnt = w_any ? (4'b0001 << w_gnt_idx) : 4'b0000;

  // The grant is gated by rst_n so that no source sees ready while the
  // design is held in reset.
  assign lsu_wb_ready = w_gnt[SRC_LSU] & rst_n;
  assign div_wb_ready = w_gnt[SRC_DIV] & rst_n;
  assign mul_wb_ready = w_gnt[SRC_MUL] & rst_n;
  assign alu_wb_ready = w_gnt[SRC_ALU] & rst_n;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    case (w_gnt_idx)
      SRC_LSU: begin w_sel_addr = lsu_wb_rd_addr; w_sel_data = lsu_wb_rd_data; end
      SRC_DIV: begin w_sel_addr = div_wb_rd_addr; w_sel_data = div_wb_rd_data; end
      SRC_MUL: begin w_sel_addr = mul_wb_rd_addr; w_sel_data = mul_wb_rd_data; end
      default: begin w_sel_addr = alu_wb_rd_addr; w_sel_data = alu_wb_rd_data; end
    endcase
  end

  // A transfer to x0 is accepted but produces no write.
  assign w_wr = w_any && (w_sel_addr != 5'd0);

  logic            r_wr_en;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge, regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_wr_en <= w_wr;
      // Address and data load only on a real write. Otherwise they keep
      // their last values.
      if (w_wr) begin
        r_rd_addr <= w_sel_addr;
        r_rd_data <= w_sel_data;
      end
    end
  end

  assign rd_wr_en = r_wr_en;
  assign rd_addr  = r_rd_addr;
  assign rd_data  = r_rd_data;

  // Scoreboard: the clear is applied first (or the flush), then the set is
  // ORed in. A set in the same cycle therefore wins over both.
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_busy_nxt;

  assign w_set      = iss_valid ? (32'd1 << iss_rd_addr) : 32'd0;
  assign w_clr      = r_wr_en   ? (32'd1 << r_rd_addr)   : 32'd0;
  assign w_busy_nxt = ((flush ? 32'd0 : (r_busy & ~w_clr)) | w_set) & ~32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_wb_arb -- directed self-checking bench for wb_arb.
// Inputs change 1 time unit after a rising edge. Combinational readies are
// sampled 1 time unit later, and registered outputs 1 time unit after the
// next rising edge. Grants are compared as the vector
// {alu, mul, div, lsu} ready.
// ---------------------------------------------------------------------------
module tb_wb_arb;
  import wb_arb_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            lsu_wb_valid, div_wb_valid, mul_wb_valid, alu_wb_valid;
  logic [4:0]      lsu_wb_rd_addr, div_wb_rd_addr, mul_wb_rd_addr, alu_wb_rd_addr;
  logic [XLEN-1:0] lsu_wb_rd_data, div_wb_rd_data, mul_wb_rd_data, alu_wb_rd_data;
  logic            lsu_wb_ready, div_wb_ready, mul_wb_ready, alu_wb_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd_addr;
  logic            flush;
  logic            rd_wr_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     busy;

  int n_checks = 0;
  int n_errors = 0;

  wb_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_wb_valid   (lsu_wb_valid),
    .lsu_wb_rd_addr (lsu_wb_rd_addr),
    .lsu_wb_rd_data (lsu_wb_rd_data),
    .lsu_wb_ready   (lsu_wb_ready),
    .div_wb_valid   (div_wb_valid),
    .div_wb_rd_addr (div_wb_rd_addr),
    .div_wb_rd_data (div_wb_rd_data),
    .div_wb_ready   (div_wb_ready),
    .mul_wb_valid   (mul_wb_valid),
    .mul_wb_rd_addr (mul_wb_rd_addr),
    .mul_wb_rd_data (mul_wb_rd_data),
    .mul_wb_ready   (mul_wb_ready),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_rd_addr (alu_wb_rd_addr),
    .alu_wb_rd_data (alu_wb_rd_data),
    .alu_wb_ready   (alu_wb_ready),
    .iss_valid      (iss_valid),
    .iss_rd_addr    (iss_rd_addr),
    .flush          (flush),
    .rd_wr_en       (rd_wr_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnt_vec();
    return {28'd0, alu_wb_ready, mul_wb_ready, div_wb_ready, lsu_wb_ready};
  endfunction

  task automatic set_valid(input int s, input logic v);
    case (s)
      0:       lsu_wb_valid = v;
      1:       div_wb_valid = v;
      2:       mul_wb_valid = v;
      default: alu_wb_valid = v;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    {lsu_wb_valid, div_wb_valid, mul_wb_valid, alu_wb_valid} = 4'b0;
    lsu_wb_rd_addr = 5'd10; lsu_wb_rd_data = 32'hA000_000A;
    div_wb_rd_addr = 5'd11; div_wb_rd_data = 32'hA000_000B;
    mul_wb_rd_addr = 5'd12; mul_wb_rd_data = 32'hA000_000C;
    alu_wb_rd_addr = 5'd13; alu_wb_rd_data = 32'hA000_000D;
    iss_valid = 1'b0; iss_rd_addr = 5'd0; flush = 1'b0;

    // ---- reset state, with a valid request present during reset ----------
    #2;
    alu_wb_valid = 1'b1;
    #1;
    check("rst_ready", gnt_vec(), 32'h0);
    check("rst_wr_en", {31'd0, rd_wr_en}, 32'h0);
    check("rst_addr", {27'd0, rd_addr}, 32'h0);
    check("rst_data", rd_data, 32'h0);
    check("rst_busy", busy, 32'h0);
    alu_wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ---- single alu writeback --------------------------------------------
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd5; alu_wb_rd_data = 32'hDEAD_BEEF;
    #1;
    check("alu_only_gnt", gnt_vec(), 32'h8);
    tick();
    alu_wb_valid = 1'b0;
    check("alu_wr_en", {31'd0, rd_wr_en}, 32'h1);
    check("alu_addr", {27'd0, rd_addr}, 32'd5);
    check("alu_data", rd_data, 32'hDEAD_BEEF);
    tick();
    check("alu_wr_en_drop", {31'd0, rd_wr_en}, 32'h0);
    check("alu_addr_hold", {27'd0, rd_addr}, 32'd5);
    check("alu_data_hold", rd_data, 32'hDEAD_BEEF);

    // ---- lsu and alu together: lsu first, then alu -----------------------
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd1; lsu_wb_rd_data = 32'h0000_0011;
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd2; alu_wb_rd_data = 32'h0000_0022;
    #1;
    check("pair_gnt0", gnt_vec(), 32'h1);
    tick();
    lsu_wb_valid = 1'b0;
    check("pair_addr0", {27'd0, rd_addr}, 32'd1);
    check("pair_data0", rd_data, 32'h11);
    #1;
    check("pair_gnt1", gnt_vec(), 32'h8);
    tick();
    alu_wb_valid = 1'b0;
    check("pair_wr_en1", {31'd0, rd_wr_en}, 32'h1);
    check("pair_addr1", {27'd0, rd_addr}, 32'd2);
    check("pair_data1", rd_data, 32'h22);

    // ---- all four held ---------------------------------------------------
    lsu_wb_rd_addr = 5'd10; lsu_wb_rd_data = 32'hA000_000A;
    div_wb_rd_addr = 5'd11; div_wb_rd_data = 32'hA000_000B;
    mul_wb_rd_addr = 5'd12; mul_wb_rd_data = 32'hA000_000C;
    alu_wb_rd_addr = 5'd13; alu_wb_rd_data = 32'hA000_000D;
    {lsu_wb_valid, div_wb_valid, mul_wb_valid, alu_wb_valid} = 4'b1111;
`ifdef WB_RR_ARB_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), gnt_vec(), 32'd1 << (i % 4));
      tick();
      check($sformatf("rr_addr%0d", i), {27'd0, rd_addr}, 32'd10 + 32'(i % 4));
    end
`else
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fixed_gnt%0d", i), gnt_vec(), 32'h1);
      tick();
      check($sformatf("fixed_addr%0d", i), {27'd0, rd_addr}, 32'd10);
    end
`endif

    // ---- drop each source once it is served: lsu, div, mul, alu ---------
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drop_gnt%0d", i), gnt_vec(), 32'd1 << i);
      tick();
      set_valid(i, 1'b0);
      check($sformatf("drop_addr%0d", i), {27'd0, rd_addr}, 32'd10 + 32'(i));
      check($sformatf("drop_data%0d", i), rd_data, 32'hA000_000A + 32'(i));
    end

    // ---- write to x0: accepted, no write, busy unchanged ----------------
    mul_wb_valid = 1'b1; mul_wb_rd_addr = 5'd0; mul_wb_rd_data = 32'h0000_1234;
    #1;
    check("x0_gnt", gnt_vec(), 32'h4);
    tick();
    mul_wb_valid = 1'b0;
    check("x0_wr_en", {31'd0, rd_wr_en}, 32'h0);
    check("x0_addr_hold", {27'd0, rd_addr}, 32'd13);
    check("x0_data_hold", rd_data, 32'hA000_000D);
    check("x0_busy", busy, 32'h0);

    // ---- scoreboard set, clear, set-wins ---------------------------------
    iss_valid = 1'b1; iss_rd_addr = 5'd7;
    tick();
    iss_valid = 1'b0;
    check("busy_set7", busy, 32'h0000_0080);
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd7; alu_wb_rd_data = 32'h0000_0077;
    tick();
    alu_wb_valid = 1'b0;
    check("wb7_wr_en", {31'd0, rd_wr_en}, 32'h1);
    check("busy_during_wr7", busy, 32'h0000_0080);
    iss_valid = 1'b1; iss_rd_addr = 5'd7;   // coincident with the clear
    tick();
    iss_valid = 1'b0;
    check("busy_set_wins", busy, 32'h0000_0080);
    alu_wb_valid = 1'b1;
    tick();
    alu_wb_valid = 1'b0;
    check("wb7b_wr_en", {31'd0, rd_wr_en}, 32'h1);
    tick();
    check("busy_clr7", busy, 32'h0);

    // ---- build busy = 0xF0, issue to x0, then flush + issue 9 -----------
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_rd_addr = 5'(4 + i);
      tick();
    end
    iss_rd_addr = 5'd0;
    tick();
    iss_valid = 1'b0;
    check("busy_f0_x0_ignored", busy, 32'h0000_00F0);
    flush = 1'b1; iss_valid = 1'b1; iss_rd_addr = 5'd9;
    div_wb_valid = 1'b1; div_wb_rd_addr = 5'd3; div_wb_rd_data = 32'h0000_0033;
    #1;
    check("flush_gnt", gnt_vec(), 32'h2);
    tick();
    flush = 1'b0; iss_valid = 1'b0; div_wb_valid = 1'b0;
    check("flush_busy", busy, 32'h0000_0200);
    check("flush_wr_en", {31'd0, rd_wr_en}, 32'h1);
    check("flush_addr", {27'd0, rd_addr}, 32'd3);

    // ---- reset pulsed during a grant -------------------------------------
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd8; lsu_wb_rd_data = 32'h0000_0088;
    #1;
    check("midrst_gnt", gnt_vec(), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", gnt_vec(), 32'h0);
    check("midrst_wr_en", {31'd0, rd_wr_en}, 32'h0);
    check("midrst_busy", busy, 32'h0);
    lsu_wb_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("postrst_wr_en", {31'd0, rd_wr_en}, 32'h0);
    check("postrst_addr", {27'd0, rd_addr}, 32'd0);
    tick();
    check("postrst_wr_en2", {31'd0, rd_wr_en}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
